// File: rtl/branch_resolve_unit_if.sv
// Fetch-side push, execute-side resolve and predictor-update signals of the branch resolve unit.
// The slave modport is the unit itself; the master modport is whoever drives fetch/execute.
interface branch_resolve_unit_if #(
    parameter int GHR_W = 10
);
    logic             f_valid;
    logic [31:0]      f_pc;
    logic             f_pred;
    logic [GHR_W-1:0] f_index;
    logic [GHR_W-1:0] f_ghr;
    logic             f_ready;

    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;

    logic             flush;
    logic [31:0]      redirect_pc;
    logic [GHR_W-1:0] redirect_ghr;
    logic             upd_valid;
    logic [GHR_W-1:0] upd_index;
    logic             upd_taken;
    logic             err;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;

    modport master (
        output f_valid, f_pc, f_pred, f_index, f_ghr,
        output ex_valid, ex_pc, ex_taken, ex_target,
        input  f_ready, flush, redirect_pc, redirect_ghr,
        input  upd_valid, upd_index, upd_taken, err, stat_branches, stat_mispred
    );

    modport slave (
        input  f_valid, f_pc, f_pred, f_index, f_ghr,
        input  ex_valid, ex_pc, ex_taken, ex_target,
        output f_ready, flush, redirect_pc, redirect_ghr,
        output upd_valid, upd_index, upd_taken, err, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted branches checked against execute outcomes; flushes and repairs history on a mispredict.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int GHR_W = 10
) (
    input  logic             clk,
    input  logic             rstn,
    branch_resolve_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W:0] ptr_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic             pred;
        logic [GHR_W-1:0] index;
        logic [GHR_W-1:0] ghr;
    } entry_t;

    entry_t           mem [DEPTH];
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic             flush_q;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [GHR_W-1:0] redirect_ghr_q, redirect_ghr_d;
    logic             upd_valid_q;
    logic [GHR_W-1:0] upd_index_q, upd_index_d;
    logic             upd_taken_q, upd_taken_d;
    logic             err_q, err_d;

    entry_t head;
    logic   empty, full;
    logic   match, flush_now, push_ok;

    // Extra wrap bit on each pointer tells full from empty when the index bits are equal.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) &&
                   (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]);
    assign head  = mem[rd_ptr_q[PTR_W-1:0]];

    assign match     = bus.ex_valid && !empty && (bus.ex_pc == head.pc);
    assign flush_now = match && (head.pred != bus.ex_taken);
    // A matched resolve frees the head slot on the same edge, so a full queue may still accept.
    assign push_ok   = bus.f_valid && !flush_now && (!full || match);

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_ghr_d = redirect_ghr_q;
        upd_index_d    = upd_index_q;
        upd_taken_d    = upd_taken_q;
        err_d          = err_q;

        if (match) begin
            rd_ptr_d    = rd_ptr_q + ptr_t'(1);
            upd_index_d = head.index;
            upd_taken_d = bus.ex_taken;
        end
        if (bus.ex_valid && !match)
            err_d = 1'b1;
        if (bus.f_valid && full && !match)
            err_d = 1'b1;

        if (flush_now) begin
            wr_ptr_d       = rd_ptr_d;
            redirect_pc_d  = bus.ex_taken ? bus.ex_target : head.pc + 32'd1;
            redirect_ghr_d = {head.ghr[GHR_W-2:0], bus.ex_taken};
        end else if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            flush_q        <= 1'b0;
            redirect_pc_q  <= '0;
            redirect_ghr_q <= '0;
            upd_valid_q    <= 1'b0;
            upd_index_q    <= '0;
            upd_taken_q    <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            flush_q        <= flush_now;
            redirect_pc_q  <= redirect_pc_d;
            redirect_ghr_q <= redirect_ghr_d;
            upd_valid_q    <= match;
            upd_index_q    <= upd_index_d;
            upd_taken_q    <= upd_taken_d;
            err_q          <= err_d;
        end
    end

    // NOTE: queue storage has no reset; the pointers alone decide which slots hold live entries.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q[PTR_W-1:0]] <= '{pc: bus.f_pc, pred: bus.f_pred,
                                          index: bus.f_index, ghr: bus.f_ghr};
    end

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_q, stat_mispred_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (match)
                stat_branches_q <= stat_branches_q + 32'd1;
            if (flush_now)
                stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_mispred  = '0;
`endif

    assign bus.f_ready      = !full;
    assign bus.flush        = flush_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.redirect_ghr = redirect_ghr_q;
    assign bus.upd_valid    = upd_valid_q;
    assign bus.upd_index    = upd_index_q;
    assign bus.upd_taken    = upd_taken_q;
    assign bus.err          = err_q;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the gshare predictor. Records every predicted conditional branch at fetch in a small in-order queue and checks it against the actual outcome when it resolves at execute. On a wrong guess it flushes the pipeline, supplies the correct PC and the repaired global history, and always sends the counter-update request back to the predictor table. It sits between fetch (producer of predictions) and the execute stage (producer of outcomes).

## Interface
- `DEPTH`, default 4: in-flight branch entries; must be a power of two ≥ 2.
- `GHR_W`, default 10: global history / table index width.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `f_valid` in 1: fetch pushes a predicted branch this cycle.
- `f_pc` in 32: word-addressed PC of the branch.
- `f_pred` in 1: predicted taken.
- `f_index` in GHR_W: table index used for the prediction.
- `f_ghr` in GHR_W: global history before this branch was shifted in.
- `f_ready` out 1: queue can accept a push.
- `ex_valid` in 1: a branch resolves this cycle.
- `ex_pc` in 32: PC of the resolving branch.
- `ex_taken` in 1: actual outcome.
- `ex_target` in 32: actual taken target.
- `flush` out 1: one-cycle pulse; squash younger instructions.
- `redirect_pc` out 32: correct next PC; valid with `flush`.
- `redirect_ghr` out GHR_W: repaired history; valid with `flush`.
- `upd_valid` out 1: one-cycle pulse carrying a table update.
- `upd_index` out GHR_W: entry to update.
- `upd_taken` out 1: increment (1) or decrement (0) the 2-bit counter.
- `err` out 1: sticky protocol-error flag.
- `stat_branches` out 32: resolved-branch count (see Configuration).
- `stat_mispred` out 32: misprediction count (see Configuration).

## Operation
- Queue: circular buffer of DEPTH entries {pc, pred, index, ghr}.
  - Read and write pointers are log2(DEPTH)+1 bits wide, so full and empty are distinguished by the extra wrap bit.
  - `f_ready` = !full.
- Push: `f_valid && f_ready && !flush_now` writes at the write pointer. A push while full is dropped and sets `err`.
- Resolve, when `ex_valid`:
  - The head entry is compared with the input.
  - If the queue is empty, or `ex_pc` ≠ head.pc: no pop, no outputs, `err` set.
  - On a match: pop the head.
    - Drive `upd_valid`=1, `upd_index`=head.index, `upd_taken`=`ex_taken`.
    - Mispredict when head.pred ≠ `ex_taken`.
- Mispredict (`flush_now`):
  - Next cycle: `flush`=1.
  - `redirect_pc` = `ex_taken` ? `ex_target` : head.pc+1 (32-bit wrap).
  - `redirect_ghr` = {head.ghr[GHR_W-2:0], `ex_taken`}.
  - All remaining entries (wrong path) are discarded: write pointer ← read pointer after the pop.
  - A push in the same cycle is discarded.
- Correct prediction: no flush. `redirect_pc` and `redirect_ghr` hold their previous values.
- Simultaneous push and correct-resolve while full: both take effect, occupancy unchanged, no `err`.
- Simultaneous push and resolve while empty: the push is not visible to the resolve. This is an error case: `err` set, the push is kept.
- `err` clears only on reset.

## Timing
- Reset (asynchronous, `rstn`=0):
  - Pointers = 0 (queue empty), `f_ready`=1.
  - `flush`, `upd_valid`, `err` = 0.
  - `redirect_pc`, `redirect_ghr`, `upd_index`, `upd_taken` = 0.
  - Stat counters = 0.
  - Reset asserted mid-operation drops all entries immediately.
- `f_ready` is combinational from the pointers. All other outputs are registered.
- Latency:
  - `ex_valid` in cycle N gives `upd_valid`/`flush` in cycle N+1.
  - `flush` and `upd_valid` are single-cycle pulses.
  - Back-to-back resolves give back-to-back pulses.
- A push in cycle N becomes visible to a resolve in cycle N+1 or later.
- An entry popped in cycle N frees its slot for a push in cycle N (same-edge pop and push).
- A flush in cycle N+1 does not block pushes in N+1. Fetch is expected to restart from `redirect_pc`.

## Configuration
- `BRU_STATS_EN` defined:
  - `stat_branches` increments on every matched resolve.
  - `stat_mispred` increments on every mispredict.
  - Both are 32-bit, wrap at 2^32, and update in cycle N+1 together with `upd_valid`.
- `BRU_STATS_EN` not defined: both outputs are constant 0 and no counter logic is built.

## Test plan
- Push pc=0x10 pred=1 idx=0x05, then resolve pc=0x10 taken=1 → next cycle: `upd_valid`=1, `upd_index`=0x05, `upd_taken`=1, `flush`=0; queue becomes empty.
- Push pc=0x20 pred=1 ghr=0x3FF, resolve taken=0 → `flush`=1, `redirect_pc`=0x21, `redirect_ghr`=0x3FE, `upd_taken`=0.
- Push pc=0x30 pred=0, push 0x31, push 0x32; resolve 0x30 taken=1 target=0x80 → `flush`=1, `redirect_pc`=0x80; queue empty afterwards, and resolving 0x31 then sets `err`.
- Fill 4 entries → `f_ready`=0. A fifth push with no resolve is dropped and sets `err`. A push together with a correct resolve is accepted, occupancy stays 4, 6 pushes total wrap the pointers correctly.
- Resolve with an empty queue, or with a mismatched `ex_pc` → no `upd_valid`, `err`=1 until `rstn` pulse; assert `rstn` low mid-stream → `f_ready`=1 and all outputs 0 immediately.
- With `BRU_STATS_EN`: 5 resolves including 2 mispredicts → `stat_branches`=5, `stat_mispred`=2. Without it: both read 0.
